btn_conditioner: RTL
====================

# btn_conditioner

Input conditioning stage for the lab4 push-button combination lock. It takes two raw, asynchronous, bouncing push-button levels and turns each press into a clean single-cycle pulse on `b0` / `b1`. These outputs drive the lock FSM's `b0` / `b1` inputs directly. Each channel has a two-flop synchronizer, a debounce counter and a rising-edge one-shot, and simultaneous presses on both channels are rejected.

## Interface
- `DEBOUNCE`, default 1_000_000: number of consecutive clock cycles a synchronized level must differ from the debounced level before it is accepted. Legal range 2 .. 2^CNT_W − 1.
- `CNT_W`, default 20: debounce counter width. Must hold DEBOUNCE − 1.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key0_raw` in 1: raw button 0, asynchronous, 1 = pressed.
- `key1_raw` in 1: raw button 1, asynchronous, 1 = pressed.
- `b0` out 1: one-cycle pulse per accepted press of button 0. Registered.
- `b1` out 1: one-cycle pulse per accepted press of button 1. Registered.
- `collide` out 1: one-cycle pulse when both channels accept a press on the same edge. Registered.
- `key_level` out 2: debounced levels, bit 0 = button 0, bit 1 = button 1. Intended for LEDs.

## Operation
- Reset (`rst` = 0, asynchronous) clears all of the following to 0:
  - sync flops `s1[i]` and `s2[i]`;
  - counters `cnt[i]`;
  - debounced levels `stable[i]`;
  - outputs `b0`, `b1`, `collide`.
  - As a result, `key_level` = 2'b00.
- Per channel i, on every clock edge:
  - `s1[i]` <= raw; `s2[i]` <= `s1[i]`.
  - If `s2[i]` == `stable[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]` == DEBOUNCE − 1: `stable[i]` <= `s2[i]`, `cnt[i]` <= 0, and the channel asserts `acc[i]`.
    - `acc[i]` is combinational: 1 only when this update is 0→1, i.e. a press.
  - Else: `cnt[i]` <= `cnt[i]` + 1.
- Releases (stable 1→0) update `key_level` but never pulse.
- Output register:
  - `b0` <= `acc[0]` & ~`acc[1]`
  - `b1` <= `acc[1]` & ~`acc[0]`
  - `collide` <= `acc[0]` & `acc[1]`
- Consequences:
  - `b0` and `b1` are never high in the same cycle.
  - `{b0,b1}` ∈ {00, 01, 10}.
- Any bounce, i.e. `s2` returning to `stable` before the count completes, restarts the count from 0. No pulse results.
- A button held indefinitely yields exactly one pulse. A new pulse requires an accepted release and then an accepted press.
- A button held through reset release is treated as a new press: it pulses once after the normal latency.
- Channels are independent. Staggered presses, even 1 cycle apart, both pulse.

## Timing
- Let raw go high and stay high, first sampled at edge N.
  - `s2` = 1 after edge N+1.
  - Count increments on edges N+2 .. N+DEBOUNCE.
  - `stable` updates at edge N+1+DEBOUNCE.
  - `b0` is high for exactly the one cycle between edges N+1+DEBOUNCE and N+2+DEBOUNCE.
- Latency from first sampling edge to pulse: DEBOUNCE + 1 edges.
- A glitch shorter than DEBOUNCE cycles, as seen at `s2`, is rejected.
- `key_level` changes on the same edge the pulse asserts.
- Counter never exceeds DEBOUNCE − 1. No wrap-around is reachable.

## Test plan
- Reset check, DEBOUNCE = 4:
  - hold `rst` = 0 with both keys 1 → `b0`, `b1`, `collide`, `key_level` all 0;
  - release `rst` → exactly one `b0` and one `b1`… rejected as a collision: `collide` = 1 for 1 cycle, `b0` = `b1` = 0.
- Clean press, DEBOUNCE = 4:
  - `key0_raw` 0→1 sampled at edge 10 → `b0` = 1 only between edges 15 and 16;
  - `key_level` = 2'b01 from edge 15;
  - no further pulse while held for 100 cycles.
- Bounce, DEBOUNCE = 4:
  - `key1_raw` toggles 1,0,1,0 with 2-cycle periods, then stays 1 → no pulse during toggling;
  - exactly one `b1` pulse, 5 edges after the last rising sample.
- Release and re-press, DEBOUNCE = 4:
  - press, hold 20 cycles, release 20 cycles, press again → two `b0` pulses and no pulse on release;
  - `key_level[0]` falls 5 edges after the release sample.
- Simultaneous vs staggered, DEBOUNCE = 4:
  - both keys rise on the same sample edge → `collide` pulse only;
  - `key1` rising 1 cycle after `key0` → `b0` pulse, then `b1` pulse on the next cycle, `collide` stays 0.
- Lock sequence feed: drive raw presses 1,0,0,1,0 (`key1`, `key0`, `key0`, `key1`, `key0`) spaced 10 cycles apart → `{b0,b1}` shows 01, 10, 10, 01, 10 as single-cycle pulses in that order.

Source files
------------

// File: rtl/btn_conditioner.sv
// Purpose : turns two raw bouncing push-buttons into clean one-cycle press pulses.
//           A press on both channels at the same edge is reported as a collision.
// Latency : DEBOUNCE+1 edges from the first edge that samples a steady raw level to the pulse.
// Backpr. : none; the pulses are fire-and-forget and the consumer must take them on that cycle.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   rst        asynchronous, active-low reset
//   key0_raw   raw button 0 level, asynchronous, 1 = pressed
//   key1_raw   raw button 1 level, asynchronous, 1 = pressed
//   b0, b1     one-cycle pulse per accepted press; a press on the other channel in the same cycle suppresses it
//   collide    one-cycle pulse when both channels accept a press on the same edge
//   key_level  debounced levels {button1, button0}, intended for LEDs
module btn_conditioner #(
   parameter int DEBOUNCE = 1_000_000,
   parameter int CNT_W    = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key0_raw,
   input  logic       key1_raw,
   output logic       b0,
   output logic       b1,
   output logic       collide,
   output logic [1:0] key_level
);

   // Last count value before a differing level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic [1:0]            raw;
   logic [1:0]            s1_q, s1_d;
   logic [1:0]            s2_q, s2_d;
   logic [1:0]            stable_q, stable_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            acc;
   logic                  b0_q, b0_d;
   logic                  b1_q, b1_d;
   logic                  collide_q, collide_d;

   assign raw = {key1_raw, key0_raw};

   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      acc      = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == stable_q[i]) begin
            // Any return to the debounced level is a bounce: restart the run.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
            // Only a 0->1 acceptance is a press; releases just move the level.
            acc[i]      = s2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      b0_d      = acc[0] & ~acc[1];
      b1_d      = acc[1] & ~acc[0];
      collide_d = acc[0] &  acc[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         stable_q  <= '0;
         cnt_q     <= '0;
         b0_q      <= 1'b0;
         b1_q      <= 1'b0;
         collide_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         collide_q <= collide_d;
      end
   end

   assign b0        = b0_q;
   assign b1        = b1_q;
   assign collide   = collide_q;
   assign key_level = stable_q;

endmodule
